// File: rtl/nand_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined NAND/AND reduction tree.
// Every tree level reduces consecutive groups of FANIN bits.
package nand_tree_pkg;

  localparam int FANIN = 4;

  // Number of tree levels needed for n inputs, never below one.
  function automatic int clog4(input int n);
    int levels;
    int span;
    levels = 1;
    span   = FANIN;
    while (span < n) begin
      span   = span * FANIN;
      levels = levels + 1;
    end
    return levels;
  endfunction

  // Lane width after padding, which is always a whole power of FANIN.
  function automatic int padded_width(input int w);
    int p;
    p = 1;
    for (int i = 0; i < clog4(w); i++) begin
      p = p * FANIN;
    end
    return p;
  endfunction

endpackage

// File: rtl/and4_stage.sv
// One registered tree level: ANDs each group of four bits per lane and optionally
// inverts the result. Holds all state while i_en is low.
module and4_stage
  import nand_tree_pkg::*;
#(
  parameter int IN_BITS  = 16,
  parameter int LANES    = 2,
  parameter bit RST_ONES = 1'b1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_en,
  input  logic                              i_valid,
  input  logic                              i_mode,
  input  logic                              i_inv,
  input  logic [LANES*IN_BITS-1:0]          i_data,
  output logic                              o_valid,
  output logic                              o_mode,
  output logic [LANES*(IN_BITS/FANIN)-1:0]  o_data
);

  localparam int OUT_BITS = IN_BITS / FANIN;

  logic [LANES*OUT_BITS-1:0] w_next;
  logic [LANES*OUT_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_mode;

  // NOTE: assign a default before the loops so no path leaves w_next unassigned (no latch).
  always_comb begin
    w_next = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int g = 0; g < OUT_BITS; g++) begin
        w_next[k*OUT_BITS + g] = (&i_data[k*IN_BITS + g*FANIN +: FANIN]) ^ i_inv;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every level samples the
  // previous level's pre-edge value, which keeps the ranks a true shift pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_mode  <= 1'b0;
      r_data  <= {(LANES*OUT_BITS){RST_ONES}};
    end else if (i_en) begin
      r_valid <= i_valid;
      r_mode  <= i_mode;
      r_data  <= w_next;
    end
  end

  assign o_valid = r_valid;
  assign o_mode  = r_mode;
  assign o_data  = r_data;

endmodule

// File: rtl/nand_tree_pipe.sv
// Pipelined, multi-lane wide NAND/AND reduction behind a valid/ready handshake.
// One register rank per 4:1 tree level; the whole pipe freezes on output backpressure.
module nand_tree_pipe
  import nand_tree_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [LANES*WIDTH-1:0] IN_DATA,
  input  logic                   IN_MODE,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [LANES-1:0]       QN,
  output logic                   OUT_MODE
);

  localparam int STAGES = clog4(WIDTH);
  localparam int PAD_W  = padded_width(WIDTH);

  logic                   w_stall;
  logic                   w_en;
  logic [LANES*PAD_W-1:0] w_pad;

  // Global stall: a held result freezes every rank, so bubbles are never squeezed out.
  assign w_stall  = OUT_VALID & ~OUT_READY;
  assign w_en     = ~w_stall;
  assign IN_READY = ~w_stall;

  // Pad each lane with ones in the MSBs; ones are the AND identity.
  always_comb begin
    w_pad = '1;
    for (int k = 0; k < LANES; k++) begin
      w_pad[k*PAD_W +: WIDTH] = IN_DATA[k*WIDTH +: WIDTH];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_lvl
    localparam int IB = PAD_W >> (2*s);
    localparam int OB = IB / FANIN;

    logic [LANES*IB-1:0] w_in;
    logic                w_vin;
    logic                w_min;
    logic                w_inv;
    logic [LANES*OB-1:0] w_q;
    logic                w_vq;
    logic                w_mq;

    if (s == 0) begin : g_first
      assign w_in  = w_pad;
      assign w_vin = IN_VALID;
      assign w_min = IN_MODE;
    end else begin : g_next
      assign w_in  = g_lvl[s-1].w_q;
      assign w_vin = g_lvl[s-1].w_vq;
      assign w_min = g_lvl[s-1].w_mq;
    end

    // Only the last level applies the carried mode; its rank is QN and resets to zero.
    assign w_inv = (s == STAGES-1) ? w_min : 1'b0;

    and4_stage #(
      .IN_BITS  (IB),
      .LANES    (LANES),
      .RST_ONES (s != STAGES-1)
    ) u_stage (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_en    (w_en),
      .i_valid (w_vin),
      .i_mode  (w_min),
      .i_inv   (w_inv),
      .i_data  (w_in),
      .o_valid (w_vq),
      .o_mode  (w_mq),
      .o_data  (w_q)
    );
  end

  assign OUT_VALID = g_lvl[STAGES-1].w_vq;
  assign OUT_MODE  = g_lvl[STAGES-1].w_mq;
  assign QN        = g_lvl[STAGES-1].w_q;

endmodule
